// File: rtl/nn_pkg.sv
// Shared types, sizes and helpers for the time-multiplexed 4-3-1 network.
package nn_pkg;

    localparam int W_W   = 8;
    localparam int FRAC  = 4;
    localparam int ACC_W = 16;
    localparam int ACT_W = 8;

    localparam int N_IN  = 4;
    localparam int N_HID = 3;
    localparam int N_W   = 15;
    localparam int N_B   = 4;

    localparam logic [4:0] CFG_B_FIRST = 5'd15;
    localparam logic [4:0] CFG_LAST    = 5'd18;

    typedef enum logic [2:0] {
        IDLE,
        HID_MAC,
        HID_ACT,
        OUT_MAC,
        OUT_ACT,
        DONE
    } state_t;

    // ReLU followed by clamp to the unsigned Q4.4 activation range.
    function automatic logic [ACT_W-1:0] sat_relu(input logic [ACC_W-1:0] acc);
        if (acc[ACC_W-1])
            return '0;
        else if (|acc[ACC_W-2:ACT_W])
            return {ACT_W{1'b1}};
        else
            return acc[ACT_W-1:0];
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Shared multiply-accumulate datapath: operand x weight, optional Q.8->Q.4
// rescale for the output layer, accumulator and saturating ReLU.
module nn_mac_unit
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_clear,
    input  logic                    i_out_layer,
    input  logic [ACT_W-1:0]        i_operand,
    input  logic signed [W_W-1:0]   i_weight,
    input  logic [2:0]              i_bias,
    output logic [ACT_W-1:0]        o_act
);

    logic signed [ACT_W+W_W:0] w_prod;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_base;
    logic signed [ACC_W-1:0]   r_acc;

    assign w_prod = $signed({1'b0, i_operand}) * i_weight;

    // Hidden products are already Q.4; output-layer products are Q.8 and floor back to Q.4.
    assign w_term = i_out_layer ? ACC_W'(w_prod >>> FRAC) : ACC_W'(w_prod);
    assign w_base = i_clear ? $signed(ACC_W'({i_bias, {FRAC{1'b0}}})) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_base + w_term;
    end

    assign o_act = sat_relu(r_acc);

endmodule

// File: rtl/nn_mac_sequencer.sv
// Sequencer for the 4-input / 3-hidden / 1-output network over one shared MAC,
// with a config register file for the 15 weights and 4 biases.
module nn_mac_sequencer
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [7:0]           i_in_x,
    input  logic                 i_cfg_we,
    input  logic [4:0]           i_cfg_addr,
    input  logic [7:0]           i_cfg_wdata,
    output logic                 o_cfg_err,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [ACT_W-1:0]     o_out_y,
    output logic [3*ACT_W-1:0]   o_h_out,
    output logic                 o_busy
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_k;
    logic [1:0]             r_n;
    logic [7:0]             r_x;
    logic signed [W_W-1:0]  r_w [N_W];
    logic [2:0]             r_b [N_B];
    logic [ACT_W-1:0]       r_h [N_HID];
    logic [ACT_W-1:0]       r_out_y;
    logic [3*ACT_W-1:0]     r_h_out;
    logic                   r_cfg_err;

    logic                   w_accept;
    logic                   w_cfg_ok;
    logic [3:0]             w_widx;
    logic [ACT_W-1:0]       w_operand;
    logic [2:0]             w_bias;
    logic [ACT_W-1:0]       w_act;
    logic [3*ACT_W-1:0]     w_h_cat;

    assign w_accept = i_in_valid && (r_state == IDLE);
    assign w_cfg_ok = i_cfg_we && (r_state == IDLE) && (i_cfg_addr <= CFG_LAST);

    // Weight wi (1-based) feeds hidden neuron ((wi-1) mod 3) from input ((wi-1) / 3).
    always_comb begin
        w_widx    = {1'b0, r_k, 1'b0} + {2'b0, r_k} + {2'b0, r_n};
        w_operand = {6'b0, r_x[{r_k, 1'b0} +: 2]};
        w_bias    = r_b[r_n];
        if (r_state == OUT_MAC) begin
            w_widx    = 4'd12 + {2'b0, r_k};
            w_operand = r_h[r_k];
            w_bias    = r_b[N_B-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_HID; gi++) begin : g_hcat
            assign w_h_cat[gi*ACT_W +: ACT_W] = r_h[gi];
        end
    endgenerate

    nn_mac_unit u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        ((r_state == HID_MAC) || (r_state == OUT_MAC)),
        .i_clear     (r_k == 2'd0),
        .i_out_layer (r_state == OUT_MAC),
        .i_operand   (w_operand),
        .i_weight    (r_w[w_widx]),
        .i_bias      (w_bias),
        .o_act       (w_act)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = HID_MAC;
            HID_MAC: if (r_k == 2'd3) w_state_next = HID_ACT;
            HID_ACT: w_state_next = (r_n == 2'd2) ? OUT_MAC : HID_MAC;
            OUT_MAC: if (r_k == 2'd2) w_state_next = OUT_ACT;
            OUT_ACT: w_state_next = DONE;
            DONE:    if (i_out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_n       <= '0;
            r_x       <= '0;
            r_out_y   <= '0;
            r_h_out   <= '0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < N_HID; i++) r_h[i] <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cfg_err <= i_cfg_we && !w_cfg_ok;
            if (w_accept) r_x <= i_in_x;

            if (r_state == HID_MAC)
                r_k <= r_k + 2'd1;
            else if (r_state == OUT_MAC && r_k != 2'd2)
                r_k <= r_k + 2'd1;
            else
                r_k <= '0;

            if (r_state == IDLE)
                r_n <= '0;
            else if (r_state == HID_ACT)
                r_n <= r_n + 2'd1;

            if (r_state == HID_ACT) r_h[r_n] <= w_act;
            if (r_state == OUT_ACT) begin
                r_out_y <= w_act;
                r_h_out <= w_h_cat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_W; i++) r_w[i] <= '0;
            for (int i = 0; i < N_B; i++) r_b[i] <= '0;
        end else if (w_cfg_ok) begin
            for (int i = 0; i < N_W; i++)
                if (i_cfg_addr == 5'(i)) r_w[i] <= i_cfg_wdata;
            for (int i = 0; i < N_B; i++)
                if (i_cfg_addr == CFG_B_FIRST + 5'(i)) r_b[i] <= i_cfg_wdata[2:0];
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_out_y     = r_out_y;
    assign o_h_out     = r_h_out;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Scoreboard bench for nn_mac_sequencer: a fixed-point reference model predicts
// each vector's activations when it is driven; results are compared on out_valid.
module tb_nn_mac_sequencer;
    import nn_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [7:0]   i_in_x = '0;
    logic         i_cfg_we = 1'b0;
    logic [4:0]   i_cfg_addr = '0;
    logic [7:0]   i_cfg_wdata = '0;
    logic         o_cfg_err;
    logic         o_out_valid;
    logic         i_out_ready = 1'b0;
    logic [7:0]   o_out_y;
    logic [23:0]  o_h_out;
    logic         o_busy;

    nn_mac_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_x      (i_in_x),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_wdata (i_cfg_wdata),
        .o_cfg_err   (o_cfg_err),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_y     (o_out_y),
        .o_h_out     (o_h_out),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    int m_w [15];
    int m_b [4];

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] h;
    } exp_t;
    exp_t sb [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_act(input int a);
        if (a < 0) return 8'h00;
        if (a > 255) return 8'hFF;
        return 8'(a);
    endfunction

    function automatic exp_t ref_model(input logic [7:0] x);
        exp_t e;
        int acc;
        logic [7:0] h [3];
        for (int n = 0; n < 3; n++) begin
            acc = m_b[n] * 16;
            for (int k = 0; k < 4; k++)
                acc += int'(x[2*k +: 2]) * m_w[k*3 + n];
            h[n] = ref_act(acc);
        end
        acc = m_b[3] * 16;
        for (int k = 0; k < 3; k++)
            acc += (int'(h[k]) * m_w[12 + k]) >>> 4;
        e.x = x;
        e.y = ref_act(acc);
        e.h = {h[2], h[1], h[0]};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [7:0] d);
        if (a < 5'd15) m_w[a] = int'($signed(d));
        else           m_b[a - 5'd15] = int'(d[2:0]);
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [7:0] d, input bit exp_err);
        i_cfg_we    = 1'b1;
        i_cfg_addr  = a;
        i_cfg_wdata = d;
        tick();
        i_cfg_we = 1'b0;
        if (!exp_err) model_write(a, d);
        check_eq("cfg_err", o_cfg_err, exp_err);
        if (exp_err) begin
            tick();
            check_eq("cfg_err_pulse_end", o_cfg_err, 1'b0);
        end
    endtask

    task automatic start_vec(input logic [7:0] x, input bit wr, input logic [4:0] a,
                             input logic [7:0] d, output int acc_cyc);
        check_eq("in_ready", o_in_ready, 1'b1);
        i_in_valid = 1'b1;
        i_in_x     = x;
        if (wr) begin
            i_cfg_we    = 1'b1;
            i_cfg_addr  = a;
            i_cfg_wdata = d;
            model_write(a, d);
        end
        sb.push_back(ref_model(x));
        tick();
        i_in_valid = 1'b0;
        i_cfg_we   = 1'b0;
        acc_cyc    = cyc;
    endtask

    task automatic finish_vec(input int acc_cyc, input bit chk_lat, input int hold);
        int   t = 0;
        exp_t e;
        logic [7:0] y0;
        if (hold == 0) i_out_ready = 1'b1;
        while (!o_out_valid && t < 200) begin
            tick();
            t++;
        end
        check_eq("out_valid", o_out_valid, 1'b1);
        if (chk_lat) check_eq("latency_edges", cyc - acc_cyc + 1, 20);
        if (sb.size() == 0) begin
            check_eq("scoreboard_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            $display("txn x=%02h y=%02h h=%06h (exp y=%02h h=%06h)", e.x, o_out_y, o_h_out, e.y, e.h);
            check_eq("out_y", o_out_y, e.y);
            check_eq("h_out", o_h_out, e.h);
        end
        y0 = o_out_y;
        for (int i = 0; i < hold; i++) begin
            i_in_valid = 1'b1;
            i_in_x     = 8'($urandom);
            tick();
            check_eq("hold_out_y", o_out_y, y0);
            check_eq("hold_in_ready", o_in_ready, 1'b0);
            check_eq("hold_out_valid", o_out_valid, 1'b1);
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        check_eq("post_hs_out_valid", o_out_valid, 1'b0);
        check_eq("post_hs_in_ready", o_in_ready, 1'b1);
    endtask

    task automatic program_all(input logic [7:0] hid_w, input logic [7:0] out_w,
                               input logic [7:0] b_hid, input logic [7:0] b_out);
        for (int i = 0; i < 12; i++) cfg_write(5'(i), hid_w, 1'b0);
        for (int i = 12; i < 15; i++) cfg_write(5'(i), out_w, 1'b0);
        for (int i = 15; i < 18; i++) cfg_write(5'(i), b_hid, 1'b0);
        cfg_write(5'd18, b_out, 1'b0);
    endtask

    task automatic run_vec(input logic [7:0] x);
        int a;
        start_vec(x, 1'b0, 5'd0, 8'd0, a);
        finish_vec(a, 1'b1, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 15; i++) m_w[i] = 0;
        for (int i = 0; i < 4; i++) m_b[i] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        clear_model();

        // Reset state
        tick();
        tick();
        check_eq("rst_out_valid", o_out_valid, 1'b0);
        check_eq("rst_cfg_err", o_cfg_err, 1'b0);
        check_eq("rst_out_y", o_out_y, 8'h00);
        check_eq("rst_h_out", o_h_out, 24'h0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_in_ready", o_in_ready, 1'b1);
        check_eq("rst_busy", o_busy, 1'b0);

        // Cleared config gives zero output
        run_vec(8'h55);

        // Scenario 1: all weights 1.0, x=1
        program_all(8'h10, 8'h10, 8'h00, 8'h00);
        run_vec(8'h55);

        // Scenario 4: write while busy is dropped, reserved address dropped
        start_vec(8'h55, 1'b0, 5'd0, 8'd0, a);
        tick();
        tick();
        check_eq("busy_mid", o_busy, 1'b1);
        cfg_write(5'd3, 8'h00, 1'b1);
        finish_vec(a, 1'b1, 0);
        run_vec(8'h55);
        cfg_write(5'd25, 8'h33, 1'b1);
        run_vec(8'h55);

        // Scenario 2: saturating hidden layer
        program_all(8'h7F, 8'h10, 8'h00, 8'h00);
        run_vec(8'hFF);

        // Scenario 3: negative hidden weights; bias4 written in the accepting cycle
        program_all(8'hF0, 8'h10, 8'h00, 8'h00);
        start_vec(8'hAA, 1'b1, 5'd18, 8'h05, a);
        finish_vec(a, 1'b1, 0);

        // Scenario 5: output back-pressure for 10 cycles, new input ignored
        program_all(8'h10, 8'h10, 8'h00, 8'h00);
        start_vec(8'h1B, 1'b0, 5'd0, 8'd0, a);
        finish_vec(a, 1'b1, 10);
        tick();
        check_eq("after_hold_busy", o_busy, 1'b0);
        run_vec(8'hE4);

        // Random configurations and inputs
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 19; i++) cfg_write(5'(i), 8'($urandom), 1'b0);
            run_vec(8'($urandom));
            run_vec(8'($urandom));
        end

        // Scenario 6: reset during OUT_MAC
        program_all(8'h20, 8'hE8, 8'h03, 8'h07);
        start_vec(8'h9C, 1'b0, 5'd0, 8'd0, a);
        repeat (16) tick();
        check_eq("pre_rst_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", o_busy, 1'b0);
        check_eq("mid_rst_out_valid", o_out_valid, 1'b0);
        check_eq("mid_rst_out_y", o_out_y, 8'h00);
        check_eq("mid_rst_h_out", o_h_out, 24'h0);
        sb.delete();
        clear_model();
        #3;
        rst_n = 1'b1;
        tick();
        run_vec(8'h55);
        program_all(8'h10, 8'h10, 8'h00, 8'h00);
        run_vec(8'h55);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
